// File: rtl/ram_dp_be.sv
// Simple dual-port RAM with per-byte write enables, 1- or 2-cycle read latency,
// and a one-word-per-cycle hardware clear sweep after reset and on request.
module ram_dp_be #(
  parameter int DW       = 16,
  parameter int AW       = 5,
  parameter int DEPTH    = 32,
  parameter int RD_LAT   = 1,
  parameter int RDW_MODE = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  output logic            busy,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [DW-1:0]   wr_data,
  input  logic [DW/8-1:0] wr_be,
  input  logic            rd_en,
  input  logic [AW-1:0]   rd_addr,
  output logic [DW-1:0]   rd_data,
  output logic            rd_valid
);

  localparam int            BW   = DW / 8;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;

  logic [DW-1:0] mem_q [DEPTH];

  logic          wr_ok, rd_ok;
  logic          wr_in_range, rd_in_range;
  logic [DW-1:0] wr_mask, old_word, rd_word;

  logic          s1_valid_q, s1_valid_d;
  logic [DW-1:0] s1_data_q, s1_data_d;

  // Sweep FSM next-state logic.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    unique case (state_q)
      CLEAR: begin
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == LAST) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      IDLE: begin
        if (clr) begin
          state_d = CLEAR;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = '0;
        busy_d  = 1'b1;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign busy = busy_q;

  always_comb begin
    wr_in_range = 32'(wr_addr) < DEPTH;
    rd_in_range = 32'(rd_addr) < DEPTH;
    wr_ok       = wr_en && !busy_q && wr_in_range;
    rd_ok       = rd_en && !busy_q;
    for (int k = 0; k < BW; k++) begin
      wr_mask[8*k +: 8] = {8{wr_be[k]}};
    end
    old_word = rd_in_range ? mem_q[rd_addr] : '0;
    // A same-address write either stays invisible (read-first) or merges in (write-first).
    if (!rd_in_range) begin
      rd_word = '0;
    end else if (RDW_MODE == 1 && wr_ok && wr_addr == rd_addr) begin
      rd_word = (old_word & ~wr_mask) | (wr_data & wr_mask);
    end else begin
      rd_word = old_word;
    end
  end

  // NOTE: the array has no reset; the sweep engine clears it so it maps onto RAM macros.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      mem_q[cnt_q] <= '0;
    end else if (wr_ok) begin
      mem_q[wr_addr] <= (mem_q[wr_addr] & ~wr_mask) | (wr_data & wr_mask);
    end
  end

  always_comb begin
    s1_valid_d = rd_ok;
    s1_data_d  = rd_ok ? rd_word : s1_data_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic          s2_valid_q, s2_valid_d;
    logic [DW-1:0] s2_data_q, s2_data_d;

    always_comb begin
      s2_valid_d = s1_valid_q;
      s2_data_d  = s1_valid_q ? s1_data_q : s2_data_q;
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        s2_valid_q <= 1'b0;
        s2_data_q  <= '0;
      end else begin
        s2_valid_q <= s2_valid_d;
        s2_data_q  <= s2_data_d;
      end
    end

    assign rd_valid = s2_valid_q;
    assign rd_data  = s2_data_q;
  end else begin : g_lat1
    assign rd_valid = s1_valid_q;
    assign rd_data  = s1_data_q;
  end

endmodule

// File: tb/tb_ram_dp_be.sv
// Drives four ram_dp_be variants (default, write-first, 2-cycle latency, DEPTH=20)
// from one directed sequence; a per-instance model queues expected responses.
module tb_ram_dp_be;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data;
  logic [1:0]  wr_be;
  logic        rd_en;
  logic [4:0]  rd_addr;

  int n_assert = 0;
  int n_fail   = 0;
  int pending [4];

  typedef struct {
    logic [15:0] data;
    int          due;
  } rsp_t;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  for (genvar d = 0; d < 4; d++) begin : g_dut
    localparam int DEP = (d == 3) ? 20 : 32;
    localparam int LAT = (d == 2) ? 2 : 1;
    localparam int RDW = (d == 1) ? 1 : 0;

    logic        busy;
    logic        rd_valid;
    logic [15:0] rd_data;

    ram_dp_be #(
      .DW(16), .AW(5), .DEPTH(DEP), .RD_LAT(LAT), .RDW_MODE(RDW)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr),
      .busy     (busy),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .wr_be    (wr_be),
      .rd_en    (rd_en),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .rd_valid (rd_valid)
    );

    logic [15:0] m_mem [32];
    bit          m_busy;
    int          m_cnt;
    int          edge_n = 0;
    rsp_t        q [$];

    // Reference behaviour, evaluated with the inputs present at each rising edge.
    always @(posedge clk or negedge rst) begin
      logic [15:0] exp;
      if (!rst) begin
        m_busy = 1'b1;
        m_cnt  = 0;
        q.delete();
        pending[d] = 0;
      end else begin
        edge_n++;
        if (m_busy) begin
          m_mem[m_cnt] = 16'h0000;
          if (m_cnt == DEP - 1) m_busy = 1'b0;
          m_cnt++;
        end else begin
          if (rd_en) begin
            exp = (int'(rd_addr) < DEP) ? m_mem[rd_addr] : 16'h0000;
            if (RDW == 1 && wr_en && wr_addr == rd_addr && int'(rd_addr) < DEP) begin
              for (int k = 0; k < 2; k++) if (wr_be[k]) exp[8*k +: 8] = wr_data[8*k +: 8];
            end
            q.push_back('{data: exp, due: edge_n + LAT - 1});
            pending[d]++;
          end
          if (wr_en && int'(wr_addr) < DEP) begin
            for (int k = 0; k < 2; k++) if (wr_be[k]) m_mem[wr_addr][8*k +: 8] = wr_data[8*k +: 8];
          end
          if (clr) begin
            m_busy = 1'b1;
            m_cnt  = 0;
          end
        end
      end
    end

    always @(negedge clk) begin
      rsp_t r;
      if (rst) begin
        check($sformatf("u%0d busy", d), 32'(busy), 32'(m_busy));
        if (rd_valid === 1'b1) begin
          if (q.size() == 0) begin
            check($sformatf("u%0d spurious rd_valid", d), 32'(1), 32'(0));
          end else begin
            r = q.pop_front();
            pending[d]--;
            check($sformatf("u%0d rd_data", d), 32'(rd_data), 32'(r.data));
            check($sformatf("u%0d rd latency", d), edge_n, r.due);
          end
        end else if (q.size() > 0 && q[0].due <= edge_n) begin
          r = q.pop_front();
          pending[d]--;
          check($sformatf("u%0d missing rd_valid", d), 32'(0), 32'(1));
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    int          n_busy0, n_busy3;
    logic [7:0]  v0, v2;
    logic [15:0] d2;

    rst = 1'b0; clr = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    wr_be = 2'b11; rd_en = 1'b0; rd_addr = '0;
    repeat (3) tick();
    check("reset busy", 32'(g_dut[0].busy), 32'(1));
    check("reset rd_valid", 32'(g_dut[0].rd_valid), 32'(0));
    check("reset rd_data", 32'(g_dut[2].rd_data), 32'(0));

    // Release, then reset again part-way through the sweep.
    rst = 1'b1;
    repeat (5) tick();
    #1 rst = 1'b0;
    tick();
    check("mid-sweep reset busy", 32'(g_dut[0].busy), 32'(1));
    rst = 1'b1;
    n_busy0 = 0; n_busy3 = 0;
    for (int i = 0; i < 40; i++) begin
      if (g_dut[0].busy) n_busy0++;
      if (g_dut[3].busy) n_busy3++;
      tick();
    end
    check("sweep cycles depth32", n_busy0, 32);
    check("sweep cycles depth20", n_busy3, 20);

    for (int a = 0; a < 32; a++) begin
      rd_en = 1'b1; rd_addr = 5'(a); tick();
    end
    rd_en = 1'b0;
    repeat (2) tick();

    // Byte-enable merge.
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 16'hA5C3; wr_be = 2'b11; tick();
    wr_data = 16'h1200; wr_be = 2'b10; tick();
    wr_en = 1'b0; rd_en = 1'b1; rd_addr = 5'd7; tick();
    rd_en = 1'b0;
    check("byte enable lat1", 32'(g_dut[0].rd_data), 32'h12C3);
    tick();
    check("byte enable lat2", 32'(g_dut[2].rd_data), 32'h12C3);

    // Read-during-write on the same address.
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 16'h0001; wr_be = 2'b11; tick();
    wr_data = 16'hBEEF; rd_en = 1'b1; rd_addr = 5'd3; tick();
    wr_en = 1'b0; rd_en = 1'b0;
    check("rdw read-first", 32'(g_dut[0].rd_data), 32'h0001);
    check("rdw write-first", 32'(g_dut[1].rd_data), 32'hBEEF);
    tick();

    // Back-to-back reads.
    for (int a = 0; a < 4; a++) begin
      wr_en = 1'b1; wr_addr = 5'(a); wr_data = 16'(16'h10 + a); wr_be = 2'b11; tick();
    end
    wr_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rd_en = (i < 4); rd_addr = 5'(i); tick();
      v0[i] = g_dut[0].rd_valid;
      v2[i] = g_dut[2].rd_valid;
      if (i == 4) d2 = g_dut[2].rd_data;
    end
    check("burst valid lat1", 32'(v0), 32'h0F);
    check("burst valid lat2", 32'(v2), 32'h1E);
    check("burst last data lat2", 32'(d2), 32'h0013);

    // Out-of-range access on the DEPTH=20 instance.
    wr_en = 1'b1; wr_addr = 5'd25; wr_data = 16'hFFFF; wr_be = 2'b11; tick();
    wr_addr = 5'd19; wr_data = 16'h1234; tick();
    wr_en = 1'b0; rd_en = 1'b1; rd_addr = 5'd25; tick();
    check("oor rd_valid", 32'(g_dut[3].rd_valid), 32'(1));
    check("oor rd_data", 32'(g_dut[3].rd_data), 32'h0000);
    check("in-range addr25", 32'(g_dut[0].rd_data), 32'hFFFF);
    rd_addr = 5'd19; tick();
    rd_en = 1'b0;
    check("last valid addr", 32'(g_dut[3].rd_data), 32'h1234);
    tick();

    // Fill, clear with traffic held high, second clr mid-sweep.
    for (int a = 0; a < 32; a++) begin
      wr_en = 1'b1; wr_addr = 5'(a); wr_data = 16'(a * 257 + 1); wr_be = 2'b11; tick();
    end
    wr_en = 1'b0; clr = 1'b1; tick();
    n_busy0 = 0;
    for (int i = 0; i < 32; i++) begin
      if (g_dut[0].busy) n_busy0++;
      clr = (i == 10); wr_en = 1'b1; rd_en = 1'b1;
      wr_addr = 5'(i); rd_addr = 5'(31 - i); wr_data = 16'hDEAD; tick();
    end
    clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (g_dut[0].busy) n_busy0++;
      tick();
    end
    check("clr sweep cycles", n_busy0, 32);

    for (int a = 0; a < 32; a++) begin
      rd_en = 1'b1; rd_addr = 5'(a); tick();
    end
    rd_en = 1'b0;
    repeat (3) tick();
    check("cleared word", 32'(g_dut[0].rd_data), 32'h0000);
    for (int d = 0; d < 4; d++) check($sformatf("u%0d outstanding reads", d), pending[d], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
